// File: rtl/window_watchdog_core_if.sv
// Watchdog configuration, service/enable inputs and status outputs bundled as one port.
// master drives configuration and stimulus; slave is the watchdog core.
interface window_watchdog_core_if;
    logic [7:0] FWLEN;
    logic [7:0] SWLEN;
    logic [7:0] RST_LMT;
    logic       WDSRVC;
    logic       INIT;
    logic       TICK;
    logic [1:0] STATE;
    logic [7:0] ERR_CNT;
    logic       WIN_OPEN;
    logic       WD_ERR;
    logic       WD_RST;

    modport master (
        output FWLEN, SWLEN, RST_LMT, WDSRVC, INIT, TICK,
        input  STATE, ERR_CNT, WIN_OPEN, WD_ERR, WD_RST
    );

    modport slave (
        input  FWLEN, SWLEN, RST_LMT, WDSRVC, INIT, TICK,
        output STATE, ERR_CNT, WIN_OPEN, WD_ERR, WD_RST
    );
endinterface

// File: rtl/window_watchdog_core.sv
// Windowed watchdog: a closed window where service is an error, then an open window that must be serviced.
// All outputs registered (events visible one cycle after the sampling edge); no backpressure, inputs sampled every cycle.
module window_watchdog_core #(
    parameter int unsigned DEC_ON_SERVICE = 1
) (
    input  logic CLK,
    input  logic RST,
    window_watchdog_core_if.slave wd
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_CLOSED = 2'b01,
        S_OPEN   = 2'b10,
        S_FAULT  = 2'b11
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic [7:0] err_cnt;
    logic       win_open;
    logic       wd_err;
    logic       wd_rst;
    logic       srv_q;
    logic       init_q;

    logic       srv_edge;
    logic       init_edge;
    logic       expire;
    logic [7:0] open_len;
    state_t     restart_state;
    logic [7:0] restart_len;
    logic [7:0] err_inc;
    logic       fault_hit;
    logic       err_event;

    always_comb begin
        srv_edge      = wd.WDSRVC & ~srv_q;
        init_edge     = wd.INIT & ~init_q;
        expire        = wd.TICK & (cnt == 8'd1);
        open_len      = (wd.SWLEN == 8'd0) ? 8'd1 : wd.SWLEN;
        restart_state = (wd.FWLEN == 8'd0) ? S_OPEN : S_CLOSED;
        restart_len   = (wd.FWLEN == 8'd0) ? open_len : wd.FWLEN;
        err_inc       = (err_cnt == 8'hFF) ? 8'hFF : err_cnt + 8'd1;
        fault_hit     = (wd.RST_LMT != 8'd0) && (err_inc >= wd.RST_LMT);
        // A service edge on the expiry tick is an error when closed but good when open.
        err_event     = ((state == S_CLOSED) && srv_edge) ||
                        ((state == S_OPEN) && expire && !srv_edge);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= S_IDLE;
            cnt      <= 8'd0;
            err_cnt  <= 8'd0;
            win_open <= 1'b0;
            wd_err   <= 1'b0;
            wd_rst   <= 1'b0;
            srv_q    <= 1'b0;
            init_q   <= 1'b0;
        end else begin
            srv_q  <= wd.WDSRVC;
            init_q <= wd.INIT;
            wd_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (init_edge) begin
                        state    <= restart_state;
                        cnt      <= restart_len;
                        win_open <= (restart_state == S_OPEN);
                    end
                end
                S_CLOSED, S_OPEN: begin
                    if (!wd.INIT) begin
                        state    <= S_IDLE;
                        cnt      <= 8'd0;
                        win_open <= 1'b0;
                    end else if (err_event) begin
                        wd_err  <= 1'b1;
                        err_cnt <= err_inc;
                        if (fault_hit) begin
                            state    <= S_FAULT;
                            cnt      <= 8'd0;
                            win_open <= 1'b0;
                            wd_rst   <= 1'b1;
                        end else begin
                            state    <= restart_state;
                            cnt      <= restart_len;
                            win_open <= (restart_state == S_OPEN);
                        end
                    end else if ((state == S_OPEN) && srv_edge) begin
                        if ((DEC_ON_SERVICE != 0) && (err_cnt != 8'd0)) begin
                            err_cnt <= err_cnt - 8'd1;
                        end
                        state    <= restart_state;
                        cnt      <= restart_len;
                        win_open <= (restart_state == S_OPEN);
                    end else if (expire) begin
                        // Only the closed window reaches here on expiry.
                        state    <= S_OPEN;
                        cnt      <= open_len;
                        win_open <= 1'b1;
                    end else if (wd.TICK) begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign wd.STATE    = state;
    assign wd.ERR_CNT  = err_cnt;
    assign wd.WIN_OPEN = win_open;
    assign wd.WD_ERR   = wd_err;
    assign wd.WD_RST   = wd_rst;
endmodule
